// File: rtl/crypto_core_adapter.sv
// ============================================================================
// Module   : crypto_core_adapter
// Function : Serialises shadowed key/text into core load beats, starts the core,
//            waits for its done handshake with timeout, and captures the result.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module crypto_core_adapter #(
    parameter int KEY_W        = 128,
    parameter int TEXT_W       = 128,
    parameter int BUS_W        = 64,
    parameter int TIMEOUT_W    = 16,
    parameter int CORE_RST_CYC = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [KEY_W-1:0]     key_i,
    input  logic [TEXT_W-1:0]    text_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [TEXT_W-1:0]    cipher_o,
    output logic                 err_timeout_o,
    output logic                 trigger_o,
    output logic                 core_rst_o,
    output logic                 core_load_o,
    output logic [BUS_W-1:0]     core_key_o,
    output logic [BUS_W-1:0]     core_data_o,
    output logic                 core_start_o,
    output logic                 core_mode_o,
    input  logic [TEXT_W-1:0]    core_data_i,
    input  logic                 core_done_i
);

    localparam int c_MAX_W   = (KEY_W > TEXT_W) ? KEY_W : TEXT_W;
    localparam int c_BEATS   = c_MAX_W / BUS_W;
    localparam int c_PAD_W   = c_BEATS * BUS_W;
    localparam int c_BCNT_W  = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_RCNT_W  = (CORE_RST_CYC > 1) ? $clog2(CORE_RST_CYC) : 1;
    localparam logic [c_BCNT_W-1:0] c_LAST_BEAT = c_BCNT_W'(c_BEATS - 1);
    localparam logic [c_RCNT_W-1:0] c_LAST_RST  = c_RCNT_W'(CORE_RST_CYC - 1);

    typedef enum logic [2:0] {
        S_RST_CORE = 3'd0,
        S_IDLE     = 3'd1,
        S_LOAD     = 3'd2,
        S_START    = 3'd3,
        S_WAIT_LO  = 3'd4,
        S_WAIT_HI  = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_start_q;
    logic [c_PAD_W-1:0]    r_key_sr;
    logic [c_PAD_W-1:0]    r_text_sr;
    logic                  r_mode;
    logic [c_BCNT_W-1:0]   r_beat_cnt;
    logic [c_RCNT_W-1:0]   r_rst_cnt;
    logic [TIMEOUT_W-1:0]  r_tmo_cnt;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic [TEXT_W-1:0]     r_cipher;
    logic                  r_err;
    logic                  r_trigger;
    logic                  r_core_rst;
    logic                  r_core_load;
    logic                  r_core_start;

    logic                  w_rise;
    logic [TIMEOUT_W-1:0]  w_tmo_next;
    logic                  w_timeout;

    assign w_rise     = start_i & ~r_start_q;
    assign w_tmo_next = r_tmo_cnt + TIMEOUT_W'(1);
    // Completion in WAIT_HI wins over a timeout landing in the same cycle.
    assign w_timeout  = ((r_state == S_WAIT_LO) || ((r_state == S_WAIT_HI) && !core_done_i))
                        && (timeout_i != '0) && (w_tmo_next == timeout_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_RST_CORE;
            r_start_q    <= 1'b0;
            r_key_sr     <= '0;
            r_text_sr    <= '0;
            r_mode       <= 1'b0;
            r_beat_cnt   <= '0;
            r_rst_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cipher     <= '0;
            r_err        <= 1'b0;
            r_trigger    <= 1'b0;
            r_core_rst   <= 1'b1;
            r_core_load  <= 1'b0;
            r_core_start <= 1'b0;
        end else begin
            r_start_q <= start_i;
            if (w_timeout) begin
                r_err      <= 1'b1;
                r_trigger  <= 1'b0;
                r_busy     <= 1'b0;
                r_core_rst <= 1'b1;
                r_rst_cnt  <= '0;
                r_state    <= S_RST_CORE;
            end else begin
                case (r_state)
                    S_RST_CORE: begin
                        if (r_rst_cnt == c_LAST_RST) begin
                            r_rst_cnt  <= '0;
                            r_core_rst <= 1'b0;
                            r_ready    <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + c_RCNT_W'(1);
                        end
                    end
                    S_IDLE: begin
                        if (w_rise) begin
                            // The shift registers double as the shadow copy.
                            r_key_sr    <= c_PAD_W'(key_i);
                            r_text_sr   <= c_PAD_W'(text_i);
                            r_mode      <= mode_i;
                            r_done      <= 1'b0;
                            r_err       <= 1'b0;
                            r_ready     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_core_load <= 1'b1;
                            r_beat_cnt  <= '0;
                            r_state     <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_key_sr  <= r_key_sr >> BUS_W;
                        r_text_sr <= r_text_sr >> BUS_W;
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_core_load  <= 1'b0;
                            r_core_start <= 1'b1;
                            r_trigger    <= 1'b1;
                            r_state      <= S_START;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_BCNT_W'(1);
                        end
                    end
                    S_START: begin
                        r_core_start <= 1'b0;
                        r_tmo_cnt    <= '0;
                        r_state      <= S_WAIT_LO;
                    end
                    S_WAIT_LO: begin
                        r_tmo_cnt <= w_tmo_next;
                        if (!core_done_i) begin
                            r_state <= S_WAIT_HI;
                        end
                    end
                    S_WAIT_HI: begin
                        r_tmo_cnt <= w_tmo_next;
                        if (core_done_i) begin
                            r_cipher  <= core_data_i;
                            r_done    <= 1'b1;
                            r_trigger <= 1'b0;
                            r_busy    <= 1'b0;
                            r_ready   <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: begin
                        r_core_rst <= 1'b1;
                        r_rst_cnt  <= '0;
                        r_state    <= S_RST_CORE;
                    end
                endcase
            end
        end
    end

    assign ready_o       = r_ready;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign cipher_o      = r_cipher;
    assign err_timeout_o = r_err;
    assign trigger_o     = r_trigger;
    assign core_rst_o    = r_core_rst;
    assign core_load_o   = r_core_load;
    assign core_key_o    = r_key_sr[BUS_W-1:0];
    assign core_data_o   = r_text_sr[BUS_W-1:0];
    assign core_start_o  = r_core_start;
    assign core_mode_o   = r_mode;

endmodule

`default_nettype wire
